// File: rtl/apb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : apb_initiator
// Purpose  : Peripheral-bus initiator. Converts single core load/store
//            requests into psel/penable transfers, waits for the responder's
//            ready pulse, and returns read data and error status. One
//            transfer is outstanding at a time. A timeout forces an error
//            response if the responder never answers.
// Ports    : pclk/presetn         - clock, async active-low reset
//            req_*                - core request channel (valid/ready)
//            rsp_*                - core response channel (valid/ready)
//            paddr/pdata/pwrite/
//            pstb/psel/penable    - bus outputs toward the responder
//            prdata/ready/perr    - responder return signals
// Revision : 1.0 - initial release
// ============================================================================
module apb_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  ready,
  input  logic                  perr
);

  // Counter wide enough to hold TIMEOUT_CYCLES itself.
  localparam int c_CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TO_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETUP  = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_RESP   = 2'd3;

  logic [1:0]            state_q,       state_d;
  logic                  req_ready_q,   req_ready_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q,       pdata_d;
  logic                  pwrite_q,      pwrite_d;
  logic [3:0]            pstb_q,        pstb_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [c_CNT_W-1:0]    cnt_q,         cnt_d;

  logic [c_CNT_W-1:0]    w_cnt_inc;

  assign w_cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pdata_d       = pdata_q;
    pwrite_d      = pwrite_q;
    pstb_d        = pstb_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      c_IDLE: begin
        // req_ready_q gates acceptance so nothing is taken in the first
        // cycle after reset release, while req_ready is still low.
        if (req_valid && req_ready_q) begin
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pdata_d   = req_write ? req_wdata : '0;
          pstb_d    = req_write ? req_wstrb : 4'b0000;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = c_SETUP;
        end
      end

      c_SETUP: begin
        penable_d = 1'b1;
        state_d   = c_ACCESS;
      end

      c_ACCESS: begin
        if (ready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = perr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = c_RESP;
        end else begin
          cnt_d = w_cnt_inc;
          // The ACCESS cycle that brings the count to the limit is the
          // last one the responder gets.
          if (w_cnt_inc == c_TO_LIMIT) begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            state_d       = c_RESP;
          end
        end
      end

      c_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = c_IDLE;
        end
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase

    // Registered so req_ready is high exactly while the FSM sits in IDLE.
    req_ready_d = (state_d == c_IDLE);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= c_IDLE;
      req_ready_q   <= 1'b0;
      paddr_q       <= '0;
      pdata_q       <= '0;
      pwrite_q      <= 1'b0;
      pstb_q        <= 4'b0000;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      paddr_q       <= paddr_d;
      pdata_q       <= pdata_d;
      pwrite_q      <= pwrite_d;
      pstb_q        <= pstb_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign paddr       = paddr_q;
  assign pdata       = pdata_q;
  assign pwrite      = pwrite_q;
  assign pstb        = pstb_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_initiator
// Purpose  : Directed self-checking bench for apb_initiator (TIMEOUT_CYCLES=4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_initiator;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        psel;
  logic        penable;
  logic [31:0] prdata = '0;
  logic        ready = 1'b0;
  logic        perr = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 pclk = ~pclk;

  apb_initiator #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr      (paddr),
    .pdata      (pdata),
    .pwrite     (pwrite),
    .pstb       (pstb),
    .psel       (psel),
    .penable    (penable),
    .prdata     (prdata),
    .ready      (ready),
    .perr       (perr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge after it is taken.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s);
    chk("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_wstrb = s;
    @(posedge pclk);
    @(negedge pclk);
    req_valid = 1'b0;
  endtask

  // Starts in SETUP, ends in RESP with the response checked.
  task automatic run_access(input string tag, input logic [31:0] e_addr,
                            input logic [31:0] e_pdata, input logic [3:0] e_pstb,
                            input logic e_pwrite, input int wait_n, input bit no_ready,
                            input logic [31:0] prd, input logic per,
                            input logic [31:0] e_rdata, input logic e_err,
                            input logic e_to);
    chk({tag, "_setup_psel"},    32'(psel),      32'd1);
    chk({tag, "_setup_penable"}, 32'(penable),   32'd0);
    chk({tag, "_setup_reqrdy"},  32'(req_ready), 32'd0);
    chk({tag, "_paddr"},         paddr,          e_addr);
    chk({tag, "_pdata"},         pdata,          e_pdata);
    chk({tag, "_pstb"},          32'(pstb),      32'(e_pstb));
    chk({tag, "_pwrite"},        32'(pwrite),    32'(e_pwrite));
    @(posedge pclk);
    @(negedge pclk);
    for (int i = 0; i < wait_n; i++) begin
      chk({tag, "_acc_psel"},    32'(psel),      32'd1);
      chk({tag, "_acc_penable"}, 32'(penable),   32'd1);
      chk({tag, "_acc_rspv"},    32'(rsp_valid), 32'd0);
      chk({tag, "_acc_paddr"},   paddr,          e_addr);
      chk({tag, "_acc_pdata"},   pdata,          e_pdata);
      chk({tag, "_acc_pstb"},    32'(pstb),      32'(e_pstb));
      chk({tag, "_acc_pwrite"},  32'(pwrite),    32'(e_pwrite));
      @(posedge pclk);
      @(negedge pclk);
    end
    if (!no_ready) begin
      ready  = 1'b1;
      prdata = prd;
      perr   = per;
      @(posedge pclk);
      @(negedge pclk);
      ready  = 1'b0;
      prdata = '0;
      perr   = 1'b0;
    end
    chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd1);
    chk({tag, "_rsp_rdata"},   rsp_rdata,        e_rdata);
    chk({tag, "_rsp_err"},     32'(rsp_err),     32'(e_err));
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(e_to));
    chk({tag, "_rsp_psel"},    32'(psel),        32'd0);
    chk({tag, "_rsp_penable"}, 32'(penable),     32'd0);
    chk({tag, "_rsp_reqrdy"},  32'(req_ready),   32'd0);
  endtask

  task automatic finish_resp(input string tag);
    rsp_ready = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk({tag, "_done_rspv"},   32'(rsp_valid), 32'd0);
    chk({tag, "_done_reqrdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge pclk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_psel",      32'(psel),      32'd0);
    chk("rst_penable",   32'(penable),   32'd0);
    chk("rst_paddr",     paddr,          32'd0);
    chk("rst_pdata",     pdata,          32'd0);
    chk("rst_pstb",      32'(pstb),      32'd0);
    chk("rst_pwrite",    32'(pwrite),    32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    // Write, ready one cycle after access starts; read data ignored for writes
    issue(1'b1, 32'h1000_0000, 32'h0000_0041, 4'hF);
    run_access("wr", 32'h1000_0000, 32'h0000_0041, 4'hF, 1'b1, 1, 1'b0,
               32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
    finish_resp("wr");

    // Read with three wait cycles; write data/strobes zeroed on the bus
    issue(1'b0, 32'h1000_0004, 32'hFFFF_FFFF, 4'hF);
    run_access("rd", 32'h1000_0004, 32'h0, 4'h0, 1'b0, 3, 1'b0,
               32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    finish_resp("rd");

    // Misaligned read, responder error
    issue(1'b0, 32'h1000_0002, 32'h0, 4'h0);
    run_access("perr", 32'h1000_0002, 32'h0, 4'h0, 1'b0, 1, 1'b0,
               32'h0BAD_0BAD, 1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0);
    finish_resp("perr");

    // Timeout after exactly 4 ACCESS cycles, then late ready pulses ignored
    issue(1'b0, 32'h1000_0010, 32'h0, 4'h0);
    run_access("to", 32'h1000_0010, 32'h0, 4'h0, 1'b0, 4, 1'b1,
               32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    ready = 1'b1; prdata = 32'h1111_1111;
    @(posedge pclk);
    @(negedge pclk);
    ready = 1'b0; prdata = '0;
    chk("to_late_rspv",  32'(rsp_valid),   32'd1);
    chk("to_late_rdata", rsp_rdata,        32'd0);
    chk("to_late_err",   32'(rsp_err),     32'd1);
    chk("to_late_to",    32'(rsp_timeout), 32'd1);
    finish_resp("to");
    ready = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    ready = 1'b0;
    chk("idle_late_psel",   32'(psel),      32'd0);
    chk("idle_late_rspv",   32'(rsp_valid), 32'd0);
    chk("idle_late_reqrdy", 32'(req_ready), 32'd1);

    // Write with no strobes is still issued
    issue(1'b1, 32'h1000_0020, 32'hA5A5_A5A5, 4'h0);
    run_access("wstrb0", 32'h1000_0020, 32'hA5A5_A5A5, 4'h0, 1'b1, 2, 1'b0,
               32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    finish_resp("wstrb0");

    // Backpressure with a second request pending
    issue(1'b0, 32'h1000_000C, 32'h0, 4'h0);
    run_access("bp", 32'h1000_000C, 32'h0, 4'h0, 1'b0, 1, 1'b0,
               32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_0008;
    req_wdata = 32'h0000_0055; req_wstrb = 4'h3;
    for (int i = 0; i < 10; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      chk("bp_hold_rspv",   32'(rsp_valid), 32'd1);
      chk("bp_hold_rdata",  rsp_rdata,      32'hCAFE_F00D);
      chk("bp_hold_reqrdy", 32'(req_ready), 32'd0);
      chk("bp_hold_psel",   32'(psel),      32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("bp_rel_rspv",   32'(rsp_valid), 32'd0);
    chk("bp_rel_reqrdy", 32'(req_ready), 32'd1);
    chk("bp_rel_psel",   32'(psel),      32'd0);
    @(posedge pclk);
    @(negedge pclk);
    req_valid = 1'b0;
    run_access("bp2", 32'h1000_0008, 32'h0000_0055, 4'h3, 1'b1, 1, 1'b0,
               32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    finish_resp("bp2");

    // Asynchronous reset during ACCESS
    issue(1'b1, 32'h1000_0030, 32'h0000_0077, 4'hF);
    @(posedge pclk);
    @(negedge pclk);
    chk("ar_pre_penable", 32'(penable), 32'd1);
    #2 presetn = 1'b0;
    #1;
    chk("ar_psel",    32'(psel),      32'd0);
    chk("ar_penable", 32'(penable),   32'd0);
    chk("ar_rspv",    32'(rsp_valid), 32'd0);
    chk("ar_reqrdy",  32'(req_ready), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("ar_post_reqrdy", 32'(req_ready), 32'd1);
    chk("ar_post_rspv",   32'(rsp_valid), 32'd0);
    issue(1'b1, 32'h1000_0040, 32'h0000_0099, 4'hF);
    run_access("ar_wr", 32'h1000_0040, 32'h0000_0099, 4'hF, 1'b1, 1, 1'b0,
               32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    finish_resp("ar_wr");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
